// File: rtl/dp_pkg.sv
// Shared definitions for the dp_core datapath: opcode encoding, FSM state
// type, flag bit positions and common widths.
package dp_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned NFLAGS = 4;
  localparam int unsigned WAIT_W = 8;

  // Flags port layout is {N,V,Z,C}
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SBC   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_PASSA = 4'd8,
    OP_INC   = 4'd9,
    OP_DEC   = 4'd10,
    OP_CMP   = 4'd11,
    OP_LOAD  = 4'd12,
    OP_STORE = 4'd13,
    OP_NOP   = 4'd14,
    OP_NOP2  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/dp_core_if.sv
// Micro-op and memory bus bundle for dp_core.
//   master: issues micro-ops, acts as memory (drives uop_*, mem_rdata, mem_ack)
//   slave : the core (drives uop_ready, mem_req/we/addr/wdata, flags, done, err)
interface dp_core_if
  import dp_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned NREG = 8
) ();

  localparam int unsigned AW = $clog2(NREG);

  logic            uop_valid;
  logic            uop_ready;
  logic [OP_W-1:0] uop_op;
  logic [AW-1:0]   uop_dst;
  logic [AW-1:0]   uop_srca;
  logic [AW-1:0]   uop_srcb;

  logic            mem_req;
  logic            mem_we;
  logic [2*W-1:0]  mem_addr;
  logic [W-1:0]    mem_wdata;
  logic [W-1:0]    mem_rdata;
  logic            mem_ack;

  logic [NFLAGS-1:0] flags;
  logic            done;
  logic            err;

  modport master (
    output uop_valid, uop_op, uop_dst, uop_srca, uop_srcb, mem_rdata, mem_ack,
    input  uop_ready, mem_req, mem_we, mem_addr, mem_wdata, flags, done, err
  );

  modport slave (
    input  uop_valid, uop_op, uop_dst, uop_srca, uop_srcb, mem_rdata, mem_ack,
    output uop_ready, mem_req, mem_we, mem_addr, mem_wdata, flags, done, err
  );

endinterface

// File: rtl/dp_alu.sv
// Combinational ALU for dp_core.
//   a, b   : operands          cin : carry flag in
//   op     : opcode            result/c/v : truncated result, carry out, signed overflow
module dp_alu
  import dp_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            cin,
  input  logic [OP_W-1:0] op,
  output logic [W-1:0]    result,
  output logic            c,
  output logic            v
);

  localparam int unsigned SW = W + 1;

  logic [W-1:0]  b_eff;
  logic          carry_in;
  logic [SW-1:0] sum;

  // Adder operand select: subtraction forms are A + ~B + carry
  always_comb begin
    b_eff    = b;
    carry_in = 1'b0;
    case (op)
      OP_ADC: carry_in = cin;
      OP_SBC: begin
        b_eff    = ~b;
        carry_in = cin;
      end
      OP_CMP: begin
        b_eff    = ~b;
        carry_in = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, b_eff} + SW'(carry_in);

  // Result and carry/overflow mux
  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SBC, OP_CMP: begin
        result = sum[W-1:0];
        c      = sum[W];
        v      = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SHL: begin
        result = {a[W-2:0], 1'b0};
        c      = a[W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[W-1:1]};
        c      = a[0];
      end
      OP_PASSA: result = a;
      OP_INC:   result = a + W'(1);
      OP_DEC:   result = a - W'(1);
      default:  ;
    endcase
  end

endmodule

// File: rtl/dp_core.sv
// Single-issue micro-op core: register file, flags, ALU execute and a
// load/store port with acknowledge timeout.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dp_core_if.slave (micro-op handshake, memory port, flags/done/err)
module dp_core
  import dp_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned NREG    = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     rst,
  dp_core_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);

  state_e state, state_nxt;

  logic [W-1:0]      regs [NREG];
  logic [NFLAGS-1:0] flags_q;
  logic [OP_W-1:0]   op_q;
  logic [AW-1:0]     dst_q;
  logic [W-1:0]      opa_q;
  logic [W-1:0]      opb_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic           ready_q;
  logic           err_q;
  logic           mem_req_q;
  logic           mem_we_q;
  logic [2*W-1:0] mem_addr_q;
  logic [W-1:0]   mem_wdata_q;

  logic accept, is_mem_op, exec_wb, load_wb, wait_inc, done_c;
  logic wr_en, upd_nz, upd_c, upd_v;

  logic [W-1:0] alu_res;
  logic         alu_c, alu_v;

  dp_alu #(.W(W)) u_alu (
    .a      (opa_q),
    .b      (opb_q),
    .cin    (flags_q[FLAG_C]),
    .op     (op_q),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v)
  );

  assign is_mem_op = (bus.uop_op == OP_LOAD) || (bus.uop_op == OP_STORE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    exec_wb   = 1'b0;
    load_wb   = 1'b0;
    wait_inc  = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.uop_valid) begin
          accept    = 1'b1;
          state_nxt = is_mem_op ? S_MEM : S_EXEC;
        end
      end
      S_EXEC: begin
        exec_wb   = 1'b1;
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          load_wb   = (op_q == OP_LOAD);
          done_c    = 1'b1;
          state_nxt = S_IDLE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          state_nxt = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Which architectural state an executing op touches
  always_comb begin
    wr_en  = 1'b0;
    upd_nz = 1'b0;
    upd_c  = 1'b0;
    upd_v  = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC, OP_SBC: begin
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        upd_c  = 1'b1;
        upd_v  = 1'b1;
      end
      OP_CMP: begin
        upd_nz = 1'b1;
        upd_c  = 1'b1;
        upd_v  = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        upd_c  = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_PASSA, OP_INC, OP_DEC: begin
        wr_en  = 1'b1;
        upd_nz = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath, register file and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      flags_q     <= '0;
      op_q        <= '0;
      dst_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      wait_cnt    <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Operands are captured at accept so dst may alias a source
      if (accept) begin
        op_q  <= bus.uop_op;
        dst_q <= bus.uop_dst;
        opa_q <= regs[bus.uop_srca];
        opb_q <= regs[bus.uop_srcb];
        if (is_mem_op) begin
          mem_we_q    <= (bus.uop_op == OP_STORE);
          mem_addr_q  <= {regs[bus.uop_srcb], regs[bus.uop_srca]};
          mem_wdata_q <= regs[bus.uop_dst];
        end
      end

      // R0 is never written, so it reads zero forever
      if (exec_wb) begin
        if (wr_en && (dst_q != '0)) regs[dst_q] <= alu_res;
        if (upd_nz) begin
          flags_q[FLAG_N] <= alu_res[W-1];
          flags_q[FLAG_Z] <= (alu_res == '0);
        end
        if (upd_c) flags_q[FLAG_C] <= alu_c;
        if (upd_v) flags_q[FLAG_V] <= alu_v;
      end

      if (load_wb && (dst_q != '0)) regs[dst_q] <= bus.mem_rdata;

      wait_cnt  <= wait_inc ? wait_cnt + WAIT_W'(1) : '0;
      ready_q   <= (state_nxt == S_IDLE);
      mem_req_q <= (state_nxt == S_MEM);
      err_q     <= (state_nxt == S_ERR);
    end
  end

  assign bus.uop_ready = ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.flags     = flags_q;
  assign bus.done      = done_c;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_dp_core.sv
// Self-checking bench for dp_core: directed scenarios plus random micro-ops
// compared against an arithmetic reference model of registers and flags.
module tb_dp_core;

  localparam int unsigned W       = 8;
  localparam int unsigned NREG    = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned TIMEOUT = 15;
  localparam int          M       = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dp_core_if #(.W(W), .NREG(NREG)) bus ();

  dp_core #(.W(W), .NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp;
  int n_bad;

  // Reference model state
  int mreg [NREG];
  int mf_n, mf_v, mf_z, mf_c;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mflags();
    return mf_n * 8 + mf_v * 4 + mf_z * 2 + mf_c;
  endfunction

  function automatic int to_signed(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic int ovf(input int x);
    return (x < -M / 2 || x > M / 2 - 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) mreg[i] = 0;
    mf_n = 0; mf_v = 0; mf_z = 0; mf_c = 0;
  endtask

  // ALU ops 0..11 on unsigned integer values
  task automatic model_exec(input int op, input int dst, input int a, input int b);
    int r, s, cin, sa, sb;
    bit wr;
    wr  = 1;
    r   = 0;
    cin = mf_c;
    sa  = to_signed(a);
    sb  = to_signed(b);
    case (op)
      0:  begin s = a + b;             r = s % M; mf_c = (s >= M); mf_v = ovf(sa + sb); end
      1:  begin s = a + b + cin;       r = s % M; mf_c = (s >= M); mf_v = ovf(sa + sb + cin); end
      2:  begin s = a + (M-1-b) + cin; r = s % M; mf_c = (s >= M); mf_v = ovf(sa - sb - 1 + cin); end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  begin r = (a * 2) % M; mf_c = (a >= M / 2); end
      7:  begin r = a / 2;       mf_c = a % 2; end
      8:  r = a;
      9:  r = (a + 1) % M;
      10: r = (a + M - 1) % M;
      11: begin s = a + (M-1-b) + 1; r = s % M; mf_c = (s >= M); mf_v = ovf(sa - sb); wr = 0; end
      default: ;
    endcase
    mf_z = (r == 0);
    mf_n = (r >= M / 2);
    if (wr && dst != 0) mreg[dst] = r;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < int'(NREG); i++)
      check($sformatf("%s_r%0d", tag, i), dut.regs[i], mreg[i]);
  endtask

  // Issue one micro-op, play the memory, check timing and resulting state.
  // ack_dly: cycles of MEM without ack before the ack cycle; -1 = never ack.
  task automatic run_uop(input int op, input int dst, input int sa, input int sb,
                         input int ack_dly, input int rdata);
    int a, b, wd, cyc, done_cyc, err_cyc, req_cyc;
    bit is_mem;
    logic [2*W-1:0] exp_addr;
    a        = mreg[sa];
    b        = mreg[sb];
    wd       = mreg[dst];
    is_mem   = (op == 12 || op == 13);
    exp_addr = (2*W)'(b * M + a);

    cyc = 0;
    @(negedge clk);
    while (!bus.uop_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_issue", bus.uop_ready, 1);

    bus.uop_valid = 1'b1;
    bus.uop_op    = 4'(op);
    bus.uop_dst   = AW'(dst);
    bus.uop_srca  = AW'(sa);
    bus.uop_srcb  = AW'(sb);
    @(posedge clk);
    #1;
    bus.uop_valid = 1'b0;
    bus.uop_dst   = AW'($urandom);
    bus.uop_srca  = AW'($urandom);
    bus.uop_srcb  = AW'($urandom);
    bus.uop_op    = 4'($urandom);

    done_cyc = 0;
    err_cyc  = 0;
    req_cyc  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (is_mem) bus.mem_ack = bus.mem_req && (ack_dly >= 0) && (c == ack_dly + 1);
      else        bus.mem_ack = 1'($urandom_range(0, 1));
      bus.mem_rdata = (is_mem && bus.mem_ack) ? W'(rdata) : W'($urandom);
      #1;
      if (bus.mem_req) begin
        req_cyc++;
        check("mem_addr", bus.mem_addr, exp_addr);
        check("mem_we", bus.mem_we, (op == 13) ? 1 : 0);
        if (op == 13) check("mem_wdata", bus.mem_wdata, wd);
      end
      if (bus.done) done_cyc = c;
      if (bus.err)  err_cyc  = c;
      if (bus.done || bus.err) break;
    end
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;

    if (is_mem && ack_dly < 0) begin
      check("timeout_err_cycle", err_cyc, TIMEOUT + 1);
      check("timeout_no_done", done_cyc, 0);
      check("timeout_req_cycles", req_cyc, TIMEOUT);
    end else begin
      check("done_cycle", done_cyc, is_mem ? ack_dly + 1 : 1);
      check("no_err", err_cyc, 0);
      if (!is_mem) check("no_mem_req", req_cyc, 0);
    end

    if (op == 12 && ack_dly >= 0) begin
      if (dst != 0) mreg[dst] = rdata;
    end else if (op <= 11) begin
      model_exec(op, dst, a, b);
    end

    check("flags", bus.flags, mflags());
    check($sformatf("reg_r%0d", dst), dut.regs[dst], mreg[dst]);
    check("mem_req_after", bus.mem_req, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int op, dst, sa, sb, dly;
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.uop_valid = 1'b0;
    bus.uop_op    = '0;
    bus.uop_dst   = '0;
    bus.uop_srca  = '0;
    bus.uop_srcb  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    do_reset();
    check("rst_ready", bus.uop_ready, 1);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_flags", bus.flags, 0);
    check_all_regs("rst");

    // ADD R1 = R0 + R0 right after reset
    run_uop(0, 1, 0, 0, 0, 0);
    check("add0_r1", dut.regs[1], 8'h00);
    check("add0_flags", bus.flags, 4'b0010);

    // Signed overflow on ADD, then SBC with carry set
    run_uop(12, 1, 0, 0, 0, 8'h7F);
    run_uop(12, 2, 0, 0, 1, 8'h01);
    run_uop(0, 3, 1, 2, 0, 0);
    check("ovf_r3", dut.regs[3], 8'h80);
    check("ovf_flags", bus.flags, 4'b1100);
    run_uop(6, 6, 3, 0, 0, 0);
    check("shl_flags", bus.flags, 4'b0111);
    run_uop(2, 4, 3, 2, 0, 0);
    check("sbc_r4", dut.regs[4], 8'h7F);
    check("sbc_flags", bus.flags, 4'b0101);

    // LOAD with three wait cycles, address built from R2:R1
    run_uop(12, 1, 0, 0, 2, 8'h34);
    run_uop(12, 2, 0, 0, 0, 8'h12);
    run_uop(12, 5, 1, 2, 3, 8'hA5);
    check("load_r5", dut.regs[5], 8'hA5);
    check("load_flags", bus.flags, 4'b0101);

    // STORE that never gets an ack
    run_uop(13, 5, 1, 2, -1, 0);
    check_all_regs("timeout");

    // Write to R0 is dropped but flags follow the result
    run_uop(12, 1, 0, 0, 0, 8'h80);
    run_uop(8, 0, 1, 0, 0, 0);
    check("r0_zero", dut.regs[0], 8'h00);
    check("r0_flag_n", bus.flags[3], 1);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      op  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) op = 12;
      dst = $urandom_range(0, NREG - 1);
      sa  = $urandom_range(0, NREG - 1);
      sb  = $urandom_range(0, NREG - 1);
      dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      run_uop(op, dst, sa, sb, dly, $urandom_range(0, M - 1));
    end
    check_all_regs("rand");

    // Reset in the middle of a LOAD, then a late ack
    @(negedge clk);
    bus.uop_valid = 1'b1;
    bus.uop_op    = 4'd12;
    bus.uop_dst   = AW'(3);
    bus.uop_srca  = AW'(1);
    bus.uop_srcb  = AW'(2);
    @(posedge clk);
    #1;
    bus.uop_valid = 1'b0;
    @(negedge clk);
    check("midmem_req_pre", bus.mem_req, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midmem_req_drop", bus.mem_req, 0);
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hFF;
    #1;
    check("late_ack_no_done", bus.done, 0);
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    model_reset();
    check("late_ack_req", bus.mem_req, 0);
    check("late_ack_flags", bus.flags, 0);
    check("late_ack_ready", bus.uop_ready, 1);
    check_all_regs("midmem");

    // Core still operational afterwards
    run_uop(9, 1, 0, 0, 0, 0);
    check("post_rst_inc", dut.regs[1], 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
